// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - bfloat16 format constants and the packed operand type
package bf16_pkg;

    localparam int BF16_SIGN_W = 1;
    localparam int BF16_EXP_W  = 8;
    localparam int BF16_MAN_W  = 7;
    localparam int BF16_BIAS   = 127;

    localparam logic [BF16_EXP_W-1:0] BF16_EXP_MAX = 8'hFF;
    localparam logic [15:0]           BF16_QNAN    = 16'h7FC0;

    typedef struct packed {
        logic                  s;
        logic [BF16_EXP_W-1:0] e;
        logic [BF16_MAN_W-1:0] m;
    } bf16_t;

endpackage

// File: rtl/bf16_lzc.sv
// rtl/bf16_lzc.sv - 11-bit leading-zero counter for the adder normalize step
module bf16_lzc (
    input  logic [10:0] value,
    output logic [3:0]  count
);

    // Scan upward so the most significant set bit is the last one to write count.
    always_comb begin
        count = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (value[i]) begin
                count = 4'(10 - i);
            end
        end
    end

endmodule

// File: rtl/bf16_adder.sv
// rtl/bf16_adder.sv - registered bfloat16 adder, RNE rounding, one-cycle latency
// Define BF16_DENORM_EN for subnormal inputs/results; otherwise flush-to-zero.
module bf16_adder
    import bf16_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sa_i,
    input  logic [7:0] ea_i,
    input  logic [6:0] ma_i,
    input  logic       sb_i,
    input  logic [7:0] eb_i,
    input  logic [6:0] mb_i,
    output logic       s_o,
    output logic [7:0] e_o,
    output logic [6:0] m_o
);

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0] sig_a, sig_b, eff_ea, eff_eb;

    assign a_nan = (ea_i == BF16_EXP_MAX) && (ma_i != 7'h00);
    assign b_nan = (eb_i == BF16_EXP_MAX) && (mb_i != 7'h00);
    assign a_inf = (ea_i == BF16_EXP_MAX) && (ma_i == 7'h00);
    assign b_inf = (eb_i == BF16_EXP_MAX) && (mb_i == 7'h00);

`ifdef BF16_DENORM_EN
    assign a_zero = (ea_i == 8'h00) && (ma_i == 7'h00);
    assign b_zero = (eb_i == 8'h00) && (mb_i == 7'h00);
    assign sig_a  = {ea_i != 8'h00, ma_i};
    assign sig_b  = {eb_i != 8'h00, mb_i};
    assign eff_ea = (ea_i == 8'h00) ? 8'd1 : ea_i;
    assign eff_eb = (eb_i == 8'h00) ? 8'd1 : eb_i;
`else
    assign a_zero = (ea_i == 8'h00);
    assign b_zero = (eb_i == 8'h00);
    assign sig_a  = {1'b1, ma_i};
    assign sig_b  = {1'b1, mb_i};
    assign eff_ea = ea_i;
    assign eff_eb = eb_i;
`endif

    logic        a_ge, big_s;
    logic [7:0]  big_e, small_e, big_sig, small_sig, diff;
    logic [10:0] small_ext, lost_mask, aligned;
    logic [11:0] sum;

    // Align: the smaller significand carries three extra bits (guard, round, sticky).
    always_comb begin
        a_ge      = {ea_i, ma_i} >= {eb_i, mb_i};
        big_s     = a_ge ? sa_i   : sb_i;
        big_e     = a_ge ? eff_ea : eff_eb;
        small_e   = a_ge ? eff_eb : eff_ea;
        big_sig   = a_ge ? sig_a  : sig_b;
        small_sig = a_ge ? sig_b  : sig_a;
        diff      = big_e - small_e;
        small_ext = {small_sig, 3'b000};
        lost_mask = (11'd1 << diff) - 11'd1;
        if (diff >= 8'd11) begin
            aligned = 11'd1;
        end else begin
            aligned = (small_ext >> diff) | {10'd0, |(small_ext & lost_mask)};
        end
        if (sa_i ^ sb_i) begin
            sum = {1'b0, big_sig, 3'b000} - {1'b0, aligned};
        end else begin
            sum = {1'b0, big_sig, 3'b000} + {1'b0, aligned};
        end
    end

    logic [3:0] lz;

    bf16_lzc u_lzc (
        .value (sum[10:0]),
        .count (lz)
    );

    logic [3:0]        shamt;
    logic [10:0]       norm;
    logic signed [9:0] exp_n, exp_r;
    logic              round_up;
    logic [8:0]        rnd;
    logic [6:0]        mant;
`ifdef BF16_DENORM_EN
    logic [7:0]        max_shift;
`endif

    always_comb begin
        shamt = lz;
        norm  = '0;
`ifdef BF16_DENORM_EN
        max_shift = big_e - 8'd1;
`endif
        if (sum[11]) begin
            norm  = sum[11:1] | {10'd0, sum[0]};
            exp_n = $signed({2'b00, big_e}) + 10'sd1;
        end else begin
            exp_n = $signed({2'b00, big_e}) - $signed({6'd0, lz});
`ifdef BF16_DENORM_EN
            // Stop at effective exponent 1; what remains is a subnormal result.
            if ({4'd0, lz} > max_shift) begin
                shamt = max_shift[3:0];
                exp_n = '0;
            end
`endif
            norm = sum[10:0] << shamt;
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[10:3]} + {8'd0, round_up};
        exp_r    = exp_n + $signed({9'd0, rnd[8]});
        if ((exp_n == 10'sd0) && rnd[7]) begin
            exp_r = 10'sd1;
        end
        mant = rnd[8] ? 7'd0 : rnd[6:0];
    end

    logic uflow;
`ifdef BF16_DENORM_EN
    assign uflow = 1'b0;
`else
    assign uflow = (exp_n <= 10'sd0);
`endif

    bf16_t res;

    always_comb begin
        res = '0;
        if (a_nan || b_nan) begin
            res = bf16_t'(BF16_QNAN);
        end else if (a_inf && b_inf) begin
            res = (sa_i == sb_i) ? {sa_i, BF16_EXP_MAX, 7'h00} : bf16_t'(BF16_QNAN);
        end else if (a_inf) begin
            res = {sa_i, BF16_EXP_MAX, 7'h00};
        end else if (b_inf) begin
            res = {sb_i, BF16_EXP_MAX, 7'h00};
        end else if (a_zero && b_zero) begin
            res = {sa_i & sb_i, 15'd0};
        end else if (a_zero) begin
            res = {sb_i, eb_i, mb_i};
        end else if (b_zero) begin
            res = {sa_i, ea_i, ma_i};
        end else if (sum == 12'd0) begin
            res = '0;
        end else if (uflow) begin
            res = {big_s, 15'd0};
        end else if (exp_r >= 10'sd255) begin
            res = {big_s, BF16_EXP_MAX, 7'h00};
        end else begin
            res = {big_s, exp_r[7:0], mant};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_o <= 1'b0;
            e_o <= 8'h00;
            m_o <= 7'h00;
        end else begin
            s_o <= res.s;
            e_o <= res.e;
            m_o <= res.m;
        end
    end

endmodule

// File: tb/tb_bf16_adder.sv
// tb/tb_bf16_adder.sv - directed and randomized checks of bf16_adder against a real-valued model
module tb_bf16_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sa_i, sb_i;
    logic [7:0] ea_i, eb_i;
    logic [6:0] ma_i, mb_i;
    logic       s_o;
    logic [7:0] e_o;
    logic [6:0] m_o;

    int n_checks = 0;
    int n_fails  = 0;

    bf16_adder dut (
        .clk  (clk),
        .rst  (rst),
        .sa_i (sa_i),
        .ea_i (ea_i),
        .ma_i (ma_i),
        .sb_i (sb_i),
        .eb_i (eb_i),
        .mb_i (mb_i),
        .s_o  (s_o),
        .e_o  (e_o),
        .m_o  (m_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %04h expected %04h", tag, got, exp);
        end
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic bit is_zero(input logic [15:0] x);
`ifdef BF16_DENORM_EN
        return x[14:0] == 15'd0;
`else
        return x[14:7] == 8'd0;
`endif
    endfunction

    function automatic real to_real(input logic [15:0] x);
        real v;
        if (x[14:7] == 8'd0) v = real'(x[6:0]) * pow2(-133);
        else                 v = real'(128 + x[6:0]) * pow2(int'(x[14:7]) - 134);
        return x[15] ? -v : v;
    endfunction

    function automatic int rne(input real scaled);
        real fl = $floor(scaled);
        real fr = scaled - fl;
        int  q  = int'(fl);
        if (fr > 0.5 || (fr == 0.5 && (q % 2) == 1)) q++;
        return q;
    endfunction

    // Reference: exact sum in real arithmetic, then rounded to the bf16 grid.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        bit  a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 0);
        bit  b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 0);
        bit  a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 0);
        bit  b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 0);
        real s, mag;
        bit  neg;
        int  e2, biased, q;
        if (a_nan || b_nan) return 16'h7FC0;
        if (a_inf && b_inf) return (a[15] == b[15]) ? {a[15], 15'h7F80} : 16'h7FC0;
        if (a_inf) return {a[15], 15'h7F80};
        if (b_inf) return {b[15], 15'h7F80};
        if (is_zero(a) && is_zero(b)) return {a[15] & b[15], 15'd0};
        if (is_zero(a)) return b;
        if (is_zero(b)) return a;
        s = to_real(a) + to_real(b);
        if (s == 0.0) return 16'h0000;
        neg = s < 0.0;
        mag = neg ? -s : s;
        e2 = 0;
        while (mag >= pow2(e2 + 1)) e2++;
        while (mag < pow2(e2)) e2--;
        biased = e2 + 127;
        if (biased <= 0) begin
`ifdef BF16_DENORM_EN
            q = rne(mag * pow2(133));
            if (q >= 128) return {neg, 8'h01, 7'(q - 128)};
            return {neg, 8'h00, 7'(q)};
`else
            return {neg, 15'd0};
`endif
        end
        q = rne(mag / pow2(e2 - 7));
        if (q == 256) begin
            q = 128;
            biased++;
        end
        if (biased >= 255) return {neg, 15'h7F80};
        return {neg, 8'(biased), 7'(q - 128)};
    endfunction

    task automatic run(input logic [15:0] a, input logic [15:0] b, output logic [15:0] y);
        @(negedge clk);
        {sa_i, ea_i, ma_i} = a;
        {sb_i, eb_i, mb_i} = b;
        @(posedge clk);
        #1;
        y = {s_o, e_o, m_o};
    endtask

    typedef struct {
        string       tag;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
    } vec_t;

    vec_t dir[$];
    logic [15:0] got, a, b;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {sa_i, ea_i, ma_i} = 16'h3F80;
        {sb_i, eb_i, mb_i} = 16'h3F80;
        #12;
        check("reset_state", {s_o, e_o, m_o}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        dir.push_back('{"zero_pp",    16'h0000, 16'h0000, 16'h0000});
        dir.push_back('{"zero_pn",    16'h0000, 16'h8000, 16'h0000});
        dir.push_back('{"zero_nn",    16'h8000, 16'h8000, 16'h8000});
        dir.push_back('{"zero_one",   16'h0000, 16'h3F80, 16'h3F80});
        dir.push_back('{"nzero_one",  16'h8000, 16'h3F80, 16'h3F80});
        dir.push_back('{"one_one",    16'h3F80, 16'h3F80, 16'h4000});
        dir.push_back('{"cancel",     16'h3F80, 16'hBF80, 16'h0000});
        dir.push_back('{"onept5",     16'h3FC0, 16'h3FC0, 16'h4040});
        dir.push_back('{"small_add",  16'h3F80, 16'h3B00, 16'h3F80});
        dir.push_back('{"tie_even",   16'h3F80, 16'h3B80, 16'h3F80});
        dir.push_back('{"tie_up",     16'h3F81, 16'h3B80, 16'h3F82});
        dir.push_back('{"inf_ninf",   16'h7F80, 16'hFF80, 16'h7FC0});
        dir.push_back('{"inf_inf",    16'hFF80, 16'hFF80, 16'hFF80});
        dir.push_back('{"inf_fin",    16'h3F80, 16'hFF80, 16'hFF80});
        dir.push_back('{"nan",        16'h7F81, 16'h3F80, 16'h7FC0});
        dir.push_back('{"overflow",   16'h7F7F, 16'h7F7F, 16'h7F80});
`ifdef BF16_DENORM_EN
        dir.push_back('{"subnormal",  16'h0001, 16'h0001, 16'h0002});
`else
        dir.push_back('{"subnormal",  16'h0001, 16'h0001, 16'h0000});
`endif
        foreach (dir[i]) begin
            run(dir[i].a, dir[i].b, got);
            check(dir[i].tag, got, dir[i].y);
        end

        // Reset mid-stream: output clears at once, first result one cycle after release.
        run(16'h3FC0, 16'h3FC0, got);
        check("pre_reset", got, 16'h4040);
        @(negedge clk);
        {sa_i, ea_i, ma_i} = 16'h3F80;
        {sb_i, eb_i, mb_i} = 16'h3F80;
        #1 rst = 1'b1;
        #1 check("reset_async", {s_o, e_o, m_o}, 16'h0000);
        @(posedge clk);
        #1 check("reset_hold", {s_o, e_o, m_o}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("after_reset", {s_o, e_o, m_o}, 16'h4000);

        for (int n = 0; n < 600; n++) begin
            int ea, eb;
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: begin
                    ea = int'(a[14:7]);
                    eb = ea + int'($urandom_range(0, 14)) - 7;
                    if (eb < 0) eb = 0;
                    if (eb > 255) eb = 255;
                    b[14:7] = 8'(eb);
                end
                2: begin
                    b = {~a[15], a[14:0]};
                    b[2:0] = 3'($urandom);
                end
                default: begin
                    a[14:7] = 8'($urandom_range(0, 3));
                    b[14:7] = 8'($urandom_range(0, 3));
                    b[15] = $urandom_range(0, 1) == 1;
                end
            endcase
            run(a, b, got);
            check($sformatf("rand_%0d_%04h_%04h", n, a, b), got, ref_add(a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
